doppler_sweep_scheduler: RTL and testbench

- Sequences the parallel code-phase search engine across a sweep of Doppler bins for one PRN.
- For each bin it programs the carrier frequency word and bin index, pulses the search start, waits for search ready, then consumes the 2046-entry correlation power stream.
- Tracks the global peak as (bin, phase, power) and declares acquisition against a programmable threshold.
- Sits between the acquisition top-level control registers and the search datapath.

---
 rtl/acq_pkg.sv | 22 ++
 rtl/doppler_sweep_scheduler_if.sv | 34 +++
 rtl/doppler_sweep_scheduler_peak_tracker.sv | 30 +++
 rtl/doppler_sweep_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_doppler_sweep_scheduler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/acq_pkg.sv
// Shared acquisition types: B1I code constants, sweep FSM states,
// and the correlation result beat.
package acq_pkg;

    localparam int B1I_CODE_LENGTH      = 2046;
    localparam int B1I_SAMPLES_PER_CODE = 16368;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_START,
        ST_WAIT_READY,
        ST_COLLECT,
        ST_NEXT,
        ST_DONE
    } sweep_state_e;

    typedef struct packed {
        logic [31:0] power;
    } res_beat_t;

endpackage

// File: rtl/doppler_sweep_scheduler_if.sv
// Scheduler <-> code-phase search datapath link: per-bin programming,
// start/ready handshake and the correlation power stream.
interface doppler_sweep_scheduler_if
    import acq_pkg::*;
#(
    parameter int FCW_W = 32
);

    logic             search_start;
    logic [7:0]       doppler_bin;
    logic [FCW_W-1:0] carrier_fcw;
    logic             search_ready;
    logic             res_valid;
    res_beat_t        res_data;

    modport master (
        output search_start,
        output doppler_bin,
        output carrier_fcw,
        input  search_ready,
        input  res_valid,
        input  res_data
    );

    modport slave (
        input  search_start,
        input  doppler_bin,
        input  carrier_fcw,
        output search_ready,
        output res_valid,
        output res_data
    );

endinterface

// File: rtl/doppler_sweep_scheduler_peak_tracker.sv
// Global correlation peak tracker; strict compare so ties keep the
// earliest (bin, phase) seen since the last clear.
module peak_tracker
    import acq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        upd,
    input  logic [7:0]  bin,
    input  logic [10:0] phase,
    input  res_beat_t   beat,
    output logic [7:0]  best_bin,
    output logic [10:0] best_phase,
    output logic [31:0] best_power
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            best_bin   <= '0;
            best_phase <= '0;
            best_power <= '0;
        end else if (upd && (beat.power > best_power)) begin
            best_bin   <= bin;
            best_phase <= phase;
            best_power <= beat.power;
        end
    end

endmodule

// File: rtl/doppler_sweep_scheduler.sv
// Doppler bin sweep sequencer for the parallel code-phase search engine:
// programs each bin, collects its power stream and reports the peak.
module doppler_sweep_scheduler
    import acq_pkg::*;
#(
    parameter int NUM_BINS       = 41,
    parameter int CODE_LEN       = B1I_CODE_LENGTH,
    parameter int FCW_W          = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    early_stop_en,
    input  logic [31:0]             threshold,
    input  logic signed [FCW_W-1:0] fcw_center,
    input  logic signed [FCW_W-1:0] fcw_step,
    doppler_sweep_scheduler_if.master dp,
    output logic                    busy,
    output logic                    done,
    output logic                    acquired,
    output logic [7:0]              best_bin,
    output logic [10:0]             best_phase,
    output logic [31:0]             best_power,
    output logic                    timeout_err
);

    localparam int CENTER = (NUM_BINS - 1) / 2;
    localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TO_W-1:0]         TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [10:0]             PH_LAST  = 11'(CODE_LEN - 1);
    localparam logic [7:0]              BIN_LAST = 8'(NUM_BINS - 1);
    localparam logic signed [FCW_W-1:0] CENTER_W = FCW_W'(CENTER);

    sweep_state_e state_q, state_d;

    logic [7:0]       bin_q;
    logic [10:0]      phase_q;
    logic [TO_W-1:0]  to_q;
    logic [FCW_W-1:0] fcw_q;
    logic             acq_q;
    logic             to_err_q;

    logic clr_sweep;
    logic load_fcw;
    logic clr_cnt;
    logic to_inc;
    logic to_hit;
    logic ph_inc;
    logic upd;
    logic bin_inc;
    logic acq_set;
    logic acq_clr;
    logic meets_thr;

    logic signed [FCW_W-1:0] rel;
    logic signed [FCW_W-1:0] prod;
    logic [FCW_W-1:0]        fcw_d;

    assign meets_thr = (best_power >= threshold);

    // Only the low FCW_W bits of the product matter, so a same-width
    // multiply gives the required truncated signed result.
    always_comb begin
        rel   = $signed(FCW_W'(bin_q)) - CENTER_W;
        prod  = rel * fcw_step;
        fcw_d = fcw_center + prod;
    end

    always_comb begin
        state_d   = state_q;
        clr_sweep = 1'b0;
        load_fcw  = 1'b0;
        clr_cnt   = 1'b0;
        to_inc    = 1'b0;
        to_hit    = 1'b0;
        ph_inc    = 1'b0;
        upd       = 1'b0;
        bin_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr_sweep = 1'b1;
                    state_d   = ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                load_fcw = 1'b1;
                state_d  = ST_START;
            end
            ST_START: begin
                clr_cnt = 1'b1;
                state_d = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                if (dp.search_ready) begin
                    state_d = ST_COLLECT;
                end else if (to_q == TO_LAST) begin
                    to_hit  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    to_inc = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (dp.res_valid) begin
                    upd    = 1'b1;
                    ph_inc = 1'b1;
                    if (phase_q == PH_LAST) begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if ((early_stop_en && meets_thr) || (bin_q == BIN_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    bin_inc = 1'b1;
                    state_d = ST_CONFIG;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort overrides every transition and suppresses all side effects.
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            clr_sweep = 1'b0;
            load_fcw  = 1'b0;
            clr_cnt   = 1'b0;
            to_inc    = 1'b0;
            to_hit    = 1'b0;
            ph_inc    = 1'b0;
            upd       = 1'b0;
            bin_inc   = 1'b0;
        end
    end

    // Latch the verdict on entry to DONE so it is valid with the done pulse.
    assign acq_set = (state_q == ST_NEXT) && (state_d == ST_DONE);
    assign acq_clr = clr_sweep || (abort && busy);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            phase_q  <= '0;
            to_q     <= '0;
            fcw_q    <= '0;
            acq_q    <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr_sweep) begin
                bin_q    <= '0;
                to_err_q <= 1'b0;
            end else begin
                if (bin_inc) bin_q <= bin_q + 8'd1;
                if (to_hit) to_err_q <= 1'b1;
            end
            if (load_fcw) fcw_q <= fcw_d;
            if (clr_cnt) begin
                phase_q <= '0;
                to_q    <= '0;
            end else begin
                if (ph_inc) phase_q <= phase_q + 11'd1;
                if (to_inc) to_q <= to_q + 1'b1;
            end
            if (acq_clr) begin
                acq_q <= 1'b0;
            end else if (acq_set) begin
                acq_q <= meets_thr && !to_err_q;
            end
        end
    end

    peak_tracker u_peak (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_sweep),
        .upd        (upd),
        .bin        (bin_q),
        .phase      (phase_q),
        .beat       (dp.res_data),
        .best_bin   (best_bin),
        .best_phase (best_phase),
        .best_power (best_power)
    );

    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE) && !abort;
    assign dp.search_start = (state_q == ST_START) && !abort;
    assign dp.doppler_bin  = bin_q;
    assign dp.carrier_fcw  = fcw_q;
    assign acquired        = acq_q;
    assign timeout_err     = to_err_q;

endmodule

// File: tb/tb_doppler_sweep_scheduler.sv
// Randomised sweep bench: emulates the search datapath and checks the
// scheduler against a bin/phase peak model.
module tb_doppler_sweep_scheduler;

    localparam int NB = 5;
    localparam int CL = 8;
    localparam int TO = 16;
    localparam int FW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic                 early_stop_en;
    logic [31:0]          threshold;
    logic signed [FW-1:0] fcw_center;
    logic signed [FW-1:0] fcw_step;
    logic                 busy;
    logic                 done;
    logic                 acquired;
    logic [7:0]           best_bin;
    logic [10:0]          best_phase;
    logic [31:0]          best_power;
    logic                 timeout_err;

    doppler_sweep_scheduler_if #(.FCW_W(FW)) sif ();

    doppler_sweep_scheduler #(
        .NUM_BINS       (NB),
        .CODE_LEN       (CL),
        .FCW_W          (FW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .early_stop_en (early_stop_en),
        .threshold     (threshold),
        .fcw_center    (fcw_center),
        .fcw_step      (fcw_step),
        .dp            (sif.master),
        .busy          (busy),
        .done          (done),
        .acquired      (acquired),
        .best_bin      (best_bin),
        .best_phase    (best_phase),
        .best_power    (best_power),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_starts = 0;
    int n_done = 0;
    int unsigned pw [NB][CL];

    always @(negedge clk) begin
        if (sif.search_start) n_starts++;
        if (done) n_done++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        sif.search_ready = 1'b0;
        sif.res_valid    = 1'b0;
        sif.res_data     = $urandom;
        start            = 1'b0;
    endtask

    // Noise the datapath drives while the scheduler should be ignoring it.
    task automatic junk();
        sif.res_valid = ($urandom_range(0, 1) == 1);
        sif.res_data  = $urandom;
        start         = ($urandom_range(0, 3) == 0);
    endtask

    task automatic fill(input int unsigned v);
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < CL; p++)
                pw[b][p] = v;
    endtask

    task automatic run_sweep(input bit es, input int to_bin,
                             input int ab_bin, input int ab_ph);
        int unsigned e_pw;
        int e_bb, e_bp, s0, d0, nb, d, g, w;
        bit ok, fin;
        logic [31:0] efcw;
        e_pw = 0; e_bb = 0; e_bp = 0; nb = 0; fin = 0;
        early_stop_en = es;
        s0 = n_starts;
        d0 = n_done;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < NB && !fin; b++) begin
            ok = 0;
            for (int k = 0; k < 6 && !ok; k++) begin
                @(negedge clk);
                ok = sif.search_start;
            end
            chk("start_pulse", ok, 1);
            if (!ok) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                return;
            end
            nb++;
            efcw = fcw_center + (b - (NB - 1) / 2) * fcw_step;
            chk("doppler_bin", sif.doppler_bin, b);
            chk("carrier_fcw", sif.carrier_fcw, efcw);
            if (b == to_bin) begin
                ok = 0;
                w  = 0;
                for (int k = 0; k < TO + 4 && !ok; k++) begin
                    @(negedge clk);
                    w++;
                    if (done) ok = 1;
                    else junk();
                end
                idle_bus();
                chk("to_done", ok, 1);
                chk("to_latency", w, TO + 1);
                chk("to_err", timeout_err, 1);
                chk("to_acq", acquired, 0);
                chk("to_bbin", best_bin, e_bb);
                chk("to_bphase", best_phase, e_bp);
                chk("to_bpow", best_power, e_pw);
                @(negedge clk);
                chk("to_idle", busy, 0);
                fin = 1;
            end else begin
                d = $urandom_range(0, TO - 1);
                for (int i = 0; i <= d; i++) begin
                    @(negedge clk);
                    junk();
                    if (i == d) sif.search_ready = 1'b1;
                end
                for (int p = 0; p < CL; p++) begin
                    g = $urandom_range(0, 2);
                    repeat (g) begin
                        @(negedge clk);
                        idle_bus();
                    end
                    @(negedge clk);
                    idle_bus();
                    if (b == ab_bin && p == ab_ph) begin
                        abort = 1'b1;
                        @(negedge clk);
                        abort = 1'b0;
                        chk("ab_idle", busy, 0);
                        chk("ab_bbin", best_bin, e_bb);
                        chk("ab_bphase", best_phase, e_bp);
                        chk("ab_bpow", best_power, e_pw);
                        chk("ab_acq", acquired, 0);
                        repeat (3) @(negedge clk);
                        chk("ab_no_done", n_done - d0, 0);
                        chk("ab_starts", n_starts - s0, nb);
                        return;
                    end
                    sif.res_valid = 1'b1;
                    sif.res_data  = pw[b][p];
                    if (pw[b][p] > e_pw) begin
                        e_pw = pw[b][p];
                        e_bb = b;
                        e_bp = p;
                    end
                end
                @(negedge clk);
                idle_bus();
                if ((es && e_pw >= threshold) || b == NB - 1) begin
                    @(negedge clk);
                    chk("done", done, 1);
                    chk("bbin", best_bin, e_bb);
                    chk("bphase", best_phase, e_bp);
                    chk("bpow", best_power, e_pw);
                    chk("acq", acquired, e_pw >= threshold);
                    chk("to_err_clr", timeout_err, 0);
                    @(negedge clk);
                    chk("idle", busy, 0);
                    chk("acq_hold", acquired, e_pw >= threshold);
                    fin = 1;
                end
            end
        end
        chk("start_count", n_starts - s0, nb);
        chk("done_count", n_done - d0, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        early_stop_en = 1'b0;
        threshold = 32'd100;
        fcw_center = 32'sd1000;
        fcw_step = 32'sd250;
        sif.search_ready = 1'b0;
        sif.res_valid = 1'b0;
        sif.res_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sstart", sif.search_start, 0);
        chk("rst_fcw", sif.carrier_fcw, 0);
        chk("rst_bin", sif.doppler_bin, 0);
        chk("rst_bpow", best_power, 0);
        chk("rst_acq", acquired, 0);
        chk("rst_to", timeout_err, 0);

        fill(10);
        pw[1][5] = 500;
        run_sweep(0, -1, -1, -1);
        run_sweep(1, -1, -1, -1);

        threshold = 300;
        fill(10);
        pw[0][2] = 200;
        pw[2][7] = 200;
        run_sweep(0, -1, -1, -1);

        threshold = 5;
        fill(10);
        run_sweep(0, 1, -1, -1);

        fill(10);
        pw[1][3] = 500;
        run_sweep(0, -1, 1, 4);
        fill(10);
        run_sweep(0, -1, -1, -1);

        threshold = 0;
        run_sweep(1, -1, -1, -1);

        threshold = 100;
        fcw_center = -32'sd1000;
        fcw_step = -32'sd500;
        run_sweep(0, -1, -1, -1);

        for (int n = 0; n < 24; n++) begin
            int tb_, ab_;
            threshold = $urandom_range(0, 1100);
            fcw_center = $urandom;
            fcw_step = $urandom;
            for (int b = 0; b < NB; b++)
                for (int p = 0; p < CL; p++)
                    pw[b][p] = $urandom_range(0, 10) * 100;
            tb_ = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NB - 1) : -1;
            ab_ = (tb_ < 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, NB - 1) : -1;
            run_sweep($urandom_range(0, 1) == 1, tb_, ab_, $urandom_range(0, CL - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
